// File: rtl/fipo_byte_loader.sv
// Byte-to-bit-stream feeder for the serial-in/parallel-out weight memory.
// Streams TOTAL_BITS bits MSB-first per byte, then waits for end_writing with a timeout.
module fipo_byte_loader #(
  parameter int TOTAL_BITS = 312,
  parameter int BYTE_W     = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BYTE_W-1:0]               byte_in,
  input  logic                            byte_valid,
  output logic                            byte_ready,
  input  logic                            fipo_end_writing,
  output logic                            serial_out,
  output logic                            serial_en,
  output logic [$clog2(TOTAL_BITS+1)-1:0] bit_count,
  output logic                            load_busy,
  output logic                            load_done,
  output logic                            load_error,
  input  logic                            rearm
);

  // state     | meaning
  // ST_IDLE   | no load in progress, waiting for first byte
  // ST_SHIFT  | emitting one bit per cycle with serial_en high
  // ST_STALL  | byte underflow mid-load, stream paused
  // ST_WAIT   | all bits sent, waiting for fipo_end_writing
  // ST_DONE   | memory confirmed end of write, hold until rearm
  // ST_ERROR  | end_writing timed out, hold until rearm

  localparam int NBYTES = TOTAL_BITS / BYTE_W;
  localparam int CNT_W  = $clog2(TOTAL_BITS + 1);
  localparam int IDX_W  = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam int ACC_W  = $clog2(NBYTES + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STALL,
    ST_WAIT,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [BYTE_W-1:0]  shreg;
  logic [IDX_W-1:0]   bit_idx;
  logic [ACC_W-1:0]   bytes_acc;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               last_bit;
  logic               more_bytes;
  logic               accept;

  assign last_bit   = (bit_idx == IDX_W'(BYTE_W - 1));
  assign more_bytes = (bytes_acc < ACC_W'(NBYTES));
  assign accept     = byte_valid & byte_ready;

  assign serial_out = shreg[BYTE_W-1];
  assign serial_en  = (state == ST_SHIFT);
  assign load_busy  = (state == ST_SHIFT) || (state == ST_STALL) || (state == ST_WAIT);
  assign load_done  = (state == ST_DONE);
  assign load_error = (state == ST_ERROR);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_bit) begin
          byte_ready = more_bytes;
          if (!more_bytes)     state_nxt = ST_WAIT;
          else if (!byte_valid) state_nxt = ST_STALL;
        end
      end
      ST_STALL: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = ST_SHIFT;
      end
      ST_WAIT: begin
        // end_writing wins over a same-cycle timeout
        if (fipo_end_writing)      state_nxt = ST_DONE;
        else if (wait_cnt == '0)   state_nxt = ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (rearm) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      bit_idx   <= '0;
      bytes_acc <= '0;
      bit_count <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg     <= byte_in;
            bit_idx   <= '0;
            bytes_acc <= ACC_W'(1);
            bit_count <= '0;
            wait_cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          bit_count <= bit_count + CNT_W'(1);
          if (accept) begin
            shreg     <= byte_in;
            bit_idx   <= '0;
            bytes_acc <= bytes_acc + ACC_W'(1);
          end else begin
            shreg   <= shreg << 1;
            bit_idx <= last_bit ? '0 : bit_idx + IDX_W'(1);
          end
          // timeout is a down-counter armed on the way into ST_WAIT
          if (last_bit && !more_bytes) wait_cnt <= WAIT_W'(TIMEOUT - 1);
        end
        ST_STALL: begin
          if (accept) begin
            shreg     <= byte_in;
            bit_idx   <= '0;
            bytes_acc <= bytes_acc + ACC_W'(1);
          end
        end
        ST_WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        ST_DONE, ST_ERROR: begin
          if (rearm) begin
            shreg     <= '0;
            bit_idx   <= '0;
            bytes_acc <= '0;
            bit_count <= '0;
            wait_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fipo_byte_loader.sv
// Directed self-checking bench for fipo_byte_loader.
// A negedge monitor records the serial stream; each task checks its own scenario.
module tb_fipo_byte_loader;

  localparam int NB = 39;
  localparam int TB_BITS = 312;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       fipo_end_writing = 1'b0;
  logic       serial_out;
  logic       serial_en;
  logic [8:0] bit_count;
  logic       load_busy;
  logic       load_done;
  logic       load_error;
  logic       rearm = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] bytes [0:NB-1];
  logic       bits  [0:4095];
  int         en_total = 0;
  int         run_len  = 0;
  int         last_run = 0;

  fipo_byte_loader dut (
    .clk              (clk),
    .rst              (rst),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .fipo_end_writing (fipo_end_writing),
    .serial_out       (serial_out),
    .serial_en        (serial_en),
    .bit_count        (bit_count),
    .load_busy        (load_busy),
    .load_done        (load_done),
    .load_error       (load_error),
    .rearm            (rearm)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (serial_en) begin
      if (en_total < 4096) bits[en_total[11:0]] <= serial_out;
      en_total <= en_total + 1;
      run_len  <= run_len + 1;
    end else begin
      if (run_len != 0) last_run <= run_len;
      run_len <= 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Feeds bytes[0..NB-1]; optionally withholds valid for 12 cycles after byte stall_idx.
  task automatic run_load(input int stall_idx, input bit keep_valid);
    int idx = 0;
    int guard = 0;
    bit took;
    while (idx < NB && guard < 2000) begin
      byte_in    = bytes[idx];
      byte_valid = 1'b1;
      took       = byte_ready;
      tick(1);
      guard++;
      if (took) begin
        if (idx == stall_idx) begin
          byte_valid = 1'b0;
          tick(8);
          checks++;
          if (serial_en !== 1'b0 || bit_count !== 9'd80 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_entry en=%b cnt=%0d rdy=%b want en=0 cnt=80 rdy=1", serial_en, bit_count, byte_ready);
          end
          tick(4);
          checks++;
          if (serial_en !== 1'b0 || bit_count !== 9'd80) begin
            errors++;
            $display("FAIL stall_hold en=%b cnt=%0d want en=0 cnt=80", serial_en, bit_count);
          end
        end
        idx++;
      end
    end
    if (!keep_valid) byte_valid = 1'b0;
    checks++;
    if (idx != NB) begin
      errors++;
      $display("FAIL load_timeout accepted=%0d want %0d", idx, NB);
    end
  endtask

  task automatic check_stream(input string name, input int base);
    int bad = 0;
    for (int k = 0; k < TB_BITS; k++) begin
      logic [7:0] b;
      b = bytes[k / 8];
      if (bits[base + k] !== b[7 - (k % 8)]) bad++;
    end
    checks++;
    if (bad != 0 || (en_total - base) != TB_BITS) begin
      errors++;
      $display("FAIL %s bad_bits=%0d en_cycles=%0d want 0 and %0d", name, bad, en_total - base, TB_BITS);
    end
  endtask

  task automatic finish_done();
    fipo_end_writing = 1'b1;
    tick(1);
    fipo_end_writing = 1'b0;
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checks++;
    if (byte_ready !== 1'b1 || serial_en !== 1'b0 || serial_out !== 1'b0 || bit_count !== 9'd0 ||
        load_busy !== 1'b0 || load_done !== 1'b0 || load_error !== 1'b0) begin
      errors++;
      $display("FAIL reset rdy=%b en=%b so=%b cnt=%0d busy=%b done=%b err=%b want 1,0,0,0,0,0,0",
               byte_ready, serial_en, serial_out, bit_count, load_busy, load_done, load_error);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    for (int i = 0; i < NB; i++) bytes[i] = 8'(i * 37 + 5);
    base = en_total;
    run_load(-1, 1'b0);
    tick(8);
    checks++;
    if (bit_count !== 9'd312 || serial_en !== 1'b0 || load_busy !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wait cnt=%0d en=%b busy=%b done=%b want 312,0,1,0", bit_count, serial_en, load_busy, load_done);
    end
    tick(1);
    checks++;
    if (last_run != TB_BITS) begin
      errors++;
      $display("FAIL b2b_consecutive run=%0d want %0d", last_run, TB_BITS);
    end
    check_stream("b2b_stream", base);
    finish_done();
  endtask

  task automatic test_done_pattern();
    int base;
    logic [7:0] first;
    bytes[0] = 8'hA5;
    for (int i = 1; i < NB; i++) bytes[i] = 8'h00;
    base = en_total;
    run_load(-1, 1'b0);
    tick(8);
    tick(2);
    fipo_end_writing = 1'b1;
    tick(1);
    fipo_end_writing = 1'b0;
    checks++;
    if (load_done !== 1'b1 || byte_ready !== 1'b0 || load_busy !== 1'b0 || load_error !== 1'b0) begin
      errors++;
      $display("FAIL done_flags done=%b rdy=%b busy=%b err=%b want 1,0,0,0", load_done, byte_ready, load_busy, load_error);
    end
    for (int k = 0; k < 8; k++) first[7 - k] = bits[base + k];
    checks++;
    if (first !== 8'hA5) begin
      errors++;
      $display("FAIL done_first_bits got=%h want a5", first);
    end
    check_stream("done_stream", base);
    tick(3);
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL done_hold done=%b want 1", load_done);
    end
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
  endtask

  task automatic test_stall();
    int base;
    for (int i = 0; i < NB; i++) bytes[i] = 8'(8'hC3 ^ (i * 11));
    base = en_total;
    run_load(9, 1'b0);
    tick(8);
    checks++;
    if (bit_count !== 9'd312 || bits[base + 80] !== bytes[10][7]) begin
      errors++;
      $display("FAIL stall_resume cnt=%0d bit80=%b want 312 and %b", bit_count, bits[base + 80], bytes[10][7]);
    end
    check_stream("stall_stream", base);
    finish_done();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < NB; i++) bytes[i] = 8'(255 - i);
    run_load(-1, 1'b0);
    tick(8);
    tick(15);
    checks++;
    if (load_error !== 1'b0 || load_busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early err=%b busy=%b want 0,1", load_error, load_busy);
    end
    tick(1);
    checks++;
    if (load_error !== 1'b1 || load_busy !== 1'b0 || load_done !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_error err=%b busy=%b done=%b rdy=%b want 1,0,0,0", load_error, load_busy, load_done, byte_ready);
    end
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
    checks++;
    if (byte_ready !== 1'b1 || bit_count !== 9'd0 || load_error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rearm rdy=%b cnt=%0d err=%b want 1,0,0", byte_ready, bit_count, load_error);
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    int base;
    byte_in    = 8'h3C;
    byte_valid = 1'b1;
    while (bit_count != 9'd150 && guard < 400) begin
      tick(1);
      guard++;
    end
    checks++;
    if (bit_count !== 9'd150) begin
      errors++;
      $display("FAIL midrst_reach cnt=%0d want 150", bit_count);
    end
    rst = 1'b1;
    byte_valid = 1'b0;
    tick(1);
    rst = 1'b0;
    checks++;
    if (serial_en !== 1'b0 || bit_count !== 9'd0 || byte_ready !== 1'b1 || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle en=%b cnt=%0d rdy=%b busy=%b want 0,0,1,0", serial_en, bit_count, byte_ready, load_busy);
    end
    for (int i = 0; i < NB; i++) bytes[i] = 8'(i * 3 + 1);
    tick(1);
    base = en_total;
    run_load(-1, 1'b0);
    tick(9);
    check_stream("midrst_reload", base);
    finish_done();
  endtask

  task automatic test_extra_bytes();
    int base;
    for (int i = 0; i < NB; i++) bytes[i] = 8'(8'h5A + i);
    base = en_total;
    run_load(-1, 1'b1);
    tick(8);
    checks++;
    if (byte_ready !== 1'b0 || serial_en !== 1'b0) begin
      errors++;
      $display("FAIL extra_wait rdy=%b en=%b want 0,0", byte_ready, serial_en);
    end
    tick(4);
    fipo_end_writing = 1'b1;
    tick(1);
    fipo_end_writing = 1'b0;
    tick(4);
    checks++;
    if (byte_ready !== 1'b0 || load_done !== 1'b1 || (en_total - base) != TB_BITS) begin
      errors++;
      $display("FAIL extra_done rdy=%b done=%b en_cycles=%0d want 0,1,%0d", byte_ready, load_done, en_total - base, TB_BITS);
    end
    byte_valid = 1'b0;
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_done_pattern();
    test_stall();
    test_timeout();
    test_mid_reset();
    test_extra_bytes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
